// File: rtl/top.sv
// Ascon-128a encryptor for one 16-byte AD block and one 16-byte plaintext block, two rounds per clock.
// Optional macro ASCON_AD_EN enables AD processing (26-cycle frame); without it AD is empty (18-cycle frame).
module top #(
  parameter logic [63:0] IV = 64'h80800C0800000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [127:0] A,
  input  logic [127:0] P,
  output logic [127:0] C,
  output logic [127:0] T
);

  typedef enum logic [2:0] {LOAD, INIT, AD1, AD2, PT, FIN, OUT} state_t;

  localparam logic [63:0] PAD = 64'h8000000000000000;

`ifdef ASCON_AD_EN
  localparam state_t       AFTER_INIT = AD1;
  localparam logic [127:0] INIT_DSEP  = 128'd0;
`else
  localparam state_t       AFTER_INIT = PT;
  localparam logic [127:0] INIT_DSEP  = 128'd1;
`endif

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2 = x2 ^ {56'd0, 4'hF - i, i};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [319:0]   x_q, x_d;
  logic [127:0]   sk_q, sk_d;
  logic [127:0]   p_q, p_d;
  logic [127:0]   ct_q, ct_d;
  logic [127:0]   c_q, c_d;
  logic [127:0]   t_q, t_d;
`ifdef ASCON_AD_EN
  logic [127:0]   a_q, a_d;
`else
  logic           a_unused_s;
  assign a_unused_s = ^A;
`endif

  logic           p12_s;
  logic           last_s;
  logic [3:0]     ri_s;
  logic [319:0]   perm_in_s;
  logic [319:0]   perm_out_s;

  // Block-entry absorption on the first cycle of a phase, then two rounds.
  always_comb begin
    p12_s     = (state_q == INIT) || (state_q == FIN);
    last_s    = p12_s ? (cnt_q == 3'd5) : (cnt_q == 3'd3);
    ri_s      = (p12_s ? 4'd0 : 4'd4) + {cnt_q, 1'b0};
    perm_in_s = x_q;
    if (cnt_q == 3'd0) begin
      case (state_q)
`ifdef ASCON_AD_EN
        AD1:     perm_in_s[319:192] = x_q[319:192] ^ a_q;
        AD2:     perm_in_s[319:256] = x_q[319:256] ^ PAD;
`endif
        PT:      perm_in_s[319:192] = x_q[319:192] ^ p_q;
        FIN:     perm_in_s = x_q ^ {PAD, 64'd0, sk_q, 64'd0};
        default: perm_in_s = x_q;
      endcase
    end else begin
      perm_in_s = x_q;
    end
    perm_out_s = ascon_round(ascon_round(perm_in_s, ri_s), ri_s + 4'd1);
  end

  // Frame sequencing and next-state computation for every register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    sk_d    = sk_q;
    p_d     = p_q;
    ct_d    = ct_q;
    c_d     = c_q;
    t_d     = t_q;
`ifdef ASCON_AD_EN
    a_d     = a_q;
`endif
    case (state_q)
      LOAD: begin
        sk_d    = SK;
        p_d     = P;
`ifdef ASCON_AD_EN
        a_d     = A;
`endif
        x_d     = {IV, SK, N};
        cnt_d   = 3'd0;
        state_d = INIT;
      end
      INIT, AD1, AD2, PT, FIN: begin
        x_d = perm_out_s;
        if ((state_q == PT) && (cnt_q == 3'd0)) begin
          ct_d = perm_in_s[319:192];
        end else begin
          ct_d = ct_q;
        end
        if (last_s) begin
          cnt_d = 3'd0;
          case (state_q)
            INIT: begin
              x_d[127:0] = perm_out_s[127:0] ^ sk_q ^ INIT_DSEP;
              state_d    = AFTER_INIT;
            end
            AD1:     state_d = AD2;
            AD2: begin
              x_d[0]  = ~perm_out_s[0];
              state_d = PT;
            end
            PT:      state_d = FIN;
            FIN:     state_d = OUT;
            default: state_d = LOAD;
          endcase
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OUT: begin
        c_d     = ct_q;
        t_d     = x_q[127:0] ^ sk_q;
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      x_q     <= 320'd0;
      sk_q    <= 128'd0;
      p_q     <= 128'd0;
      ct_q    <= 128'd0;
      c_q     <= 128'd0;
      t_q     <= 128'd0;
`ifdef ASCON_AD_EN
      a_q     <= 128'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      sk_q    <= sk_d;
      p_q     <= p_d;
      ct_q    <= ct_d;
      c_q     <= c_d;
      t_q     <= t_d;
`ifdef ASCON_AD_EN
      a_q     <= a_d;
`endif
    end
  end

  assign C = c_q;
  assign T = t_q;

endmodule

// File: tb/tb_top.sv
// Bench for top: frame-level Ascon-128a reference (table S-box) compared every cycle, with random inputs.
module tb_top;
`ifdef ASCON_AD_EN
  localparam int FRAME = 26;
`else
  localparam int FRAME = 18;
`endif
  localparam logic [63:0]  IV  = 64'h80800C0800000000;
  localparam logic [127:0] KAT = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [159:0] SBOX = {5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
                                   5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
                                   5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
                                   5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04};

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [127:0] SK = '0, N = '0, A = '0, P = '0;
  logic [127:0] C, T;

  int checks = 0;
  int errors = 0;

  top #(.IV(IV)) dut (.CLK(CLK), .RST(RST), .SK(SK), .N(N), .A(A), .P(P), .C(C), .T(T));

  always #5 CLK = ~CLK;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Rounds first..11 applied column by column through the 5-bit S-box table.
  function automatic logic [319:0] perm(input logic [319:0] st, input int first);
    logic [63:0] x [5];
    logic [4:0]  col, o;
    for (int k = 0; k < 5; k++) x[k] = st[319 - 64*k -: 64];
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[int'(col) * 5 +: 5];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Returns {ciphertext, tag} for one AD block and one plaintext block.
  function automatic logic [255:0] ascon_enc(input logic [127:0] k, input logic [127:0] n,
                                             input logic [127:0] a, input logic [127:0] p);
    logic [319:0] s;
    logic [127:0] c;
    s = perm({IV, k, n}, 0);
    s[127:0] = s[127:0] ^ k;
`ifdef ASCON_AD_EN
    s[319:192] = s[319:192] ^ a;
    s = perm(s, 4);
    s[319:312] = s[319:312] ^ 8'h80;
    s = perm(s, 4);
`else
    begin
      logic ad_unused;
      ad_unused = ^a;
    end
`endif
    s[0] = ~s[0];
    s[319:192] = s[319:192] ^ p;
    c = s[319:192];
    s = perm(s, 4);
    s[319:312] = s[319:312] ^ 8'h80;
    s[191:64] = s[191:64] ^ k;
    s = perm(s, 0);
    return {c, s[127:0] ^ k};
  endfunction

  // Frame-level reference: inputs sampled on the first edge, results published on the last.
  int           phase = 0;
  logic [127:0] lk = '0, ln = '0, la = '0, lp = '0;
  logic [127:0] exp_c = '0, exp_t = '0;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase <= 0;
      exp_c <= '0;
      exp_t <= '0;
    end else begin
      if (phase == 0) begin
        lk <= SK; ln <= N; la <= A; lp <= P;
      end
      if (phase == FRAME - 1) {exp_c, exp_t} <= ascon_enc(lk, ln, la, lp);
      phase <= (phase == FRAME - 1) ? 0 : phase + 1;
    end
  end

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check128("C_vs_model", C, exp_c);
      check128("T_vs_model", T, exp_t);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rnd_inputs();
    SK = rnd128(); N = rnd128(); A = rnd128(); P = rnd128();
  endtask

  task automatic wait_phase(input int ph);
    int g;
    g = 0;
    while (phase != ph && g < 4 * FRAME) begin
      cyc(1);
      g++;
    end
    check128("phase_sync", 128'(phase), 128'(ph));
  endtask

  logic [255:0] r0, r1;
  logic [127:0] ok, on, oa, op;
  int n;

  initial begin
    // Model pin: flipping plaintext bit 0 flips only ciphertext bit 0 and changes the tag.
    r0 = ascon_enc(KAT, KAT, KAT, KAT);
    r1 = ascon_enc(KAT, KAT, KAT, KAT ^ 128'd1);
    check128("model_bitflip_C", r0[255:128] ^ r1[255:128], 128'd1);
    check128("model_bitflip_T", 128'(r0[127:0] != r1[127:0]), 128'd1);

    // Reset held with changing inputs.
    for (int i = 0; i < 4; i++) begin
      rnd_inputs();
      cyc(1);
      check128("reset_C", C, 128'd0);
      check128("reset_T", T, 128'd0);
    end

    // Release: first output update after exactly one frame of edges.
    SK = KAT; N = KAT; A = KAT; P = KAT;
    RST = 1'b1;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (C == 128'd0 && n < 4 * FRAME);
    check128("first_update_cycles", 128'(n), 128'(FRAME));
    check128("kat_C", C, r0[255:128]);
    check128("kat_T", T, r0[127:0]);
    cyc(3 * FRAME);

    // Plaintext bit 0 flipped.
    P = KAT ^ 128'd1;
    cyc(2 * FRAME);
    check128("bitflip_C", C, r1[255:128]);
    check128("bitflip_T", T, r1[127:0]);

    // Inputs changed mid-frame must not disturb the frame in progress.
    wait_phase(5);
    ok = lk; on = ln; oa = la; op = lp;
    rnd_inputs();
    cyc(FRAME - 5);
    r0 = ascon_enc(ok, on, oa, op);
    check128("midframe_old_C", C, r0[255:128]);
    check128("midframe_old_T", T, r0[127:0]);
    cyc(FRAME);
    r1 = ascon_enc(SK, N, A, P);
    check128("midframe_new_C", C, r1[255:128]);
    check128("midframe_new_T", T, r1[127:0]);

    // Reset late in a frame clears outputs at once, then a full frame recovers.
    wait_phase(FRAME - 6);
    RST = 1'b0;
    #1;
    check128("midreset_C", C, 128'd0);
    check128("midreset_T", T, 128'd0);
    cyc(3);
    RST = 1'b1;
    cyc(FRAME);
    r0 = ascon_enc(SK, N, A, P);
    check128("after_reset_C", C, r0[255:128]);
    check128("after_reset_T", T, r0[127:0]);

    // Inputs randomized on every cycle.
    for (int i = 0; i < 8 * FRAME; i++) begin
      rnd_inputs();
      cyc(1);
    end

    // Inputs held for random stretches.
    for (int i = 0; i < 12; i++) begin
      rnd_inputs();
      cyc($urandom_range(1, 2 * FRAME));
    end
    cyc(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
